// File: rtl/subc_ctl_bank_pkg.sv
// Shared definitions for the sub-channel controller bank: lane FSM encoding
// and default sizing.
package subc_ctl_bank_pkg;

  localparam int SUBCH_DEF  = 4;
  localparam int LEN_W_DEF  = 6;
  localparam int MAXLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2,
    ST_REL  = 2'd3
  } subc_state_e;

endpackage

// File: rtl/subc_ctl_bank_fsm.sv
// Single sub-channel controller: tracks one frame from grant to eof and
// decides when the last input-buffer stage is popped.
//
// state | meaning
// IDLE  | no frame in progress, waiting for grant or router error
// XFER  | granted; pop only when the output port accepts
// DROP  | misrouted or over-long frame; pop every valid flit locally
// REL   | frame done; hold rt_rst until the grant is withdrawn
module subc_fsm
  import subc_ctl_bank_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int MAXLEN = MAXLEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic eof,
  input  logic rt_ra,
  input  logic rt_err,
  input  logic ai2cb,
  output logic nack,
  output logic rt_rst,
  output logic busy,
  output logic ovf
);

  localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(MAXLEN - 1);
  localparam logic [LEN_W-1:0] CNT_SAT  = '1;
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  subc_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    nack    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rt_err)     state_d = ST_DROP;
        else if (rt_ra) state_d = ST_XFER;
      end
      ST_XFER: begin
        nack = vld & ai2cb;
        if (nack) begin
          cnt_d = cnt_q + CNT_ONE;
          if (eof) begin
            state_d = ST_REL;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DROP;
            ovf_d   = 1'b1;
          end
        end
      end
      ST_DROP: begin
        nack = vld;
        if (nack) begin
          // Dropping has no length limit; saturate rather than wrap.
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
          if (eof) state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!rt_ra) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) cnt_d = '0;
    if (rst) nack = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rt_rst  <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rt_rst  <= (state_d == ST_REL);
      busy    <= (state_d != ST_IDLE);
      ovf     <= ovf_d;
    end
  end

endmodule

// File: rtl/subc_ctl_bank.sv
// Bank of independent sub-channel controllers for one router input port;
// the top level only slices the per-lane vectors.
module subc_ctl_bank
  import subc_ctl_bank_pkg::*;
#(
  parameter int SUBCH  = SUBCH_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int MAXLEN = MAXLEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUBCH-1:0] vld,
  input  logic [SUBCH-1:0] eof,
  input  logic [SUBCH-1:0] rt_ra,
  input  logic [SUBCH-1:0] rt_err,
  input  logic [SUBCH-1:0] ai2cb,
  output logic [SUBCH-1:0] nack,
  output logic [SUBCH-1:0] rt_rst,
  output logic [SUBCH-1:0] busy,
  output logic [SUBCH-1:0] ovf
);

  for (genvar g = 0; g < SUBCH; g++) begin : g_lane
    subc_fsm #(
      .LEN_W (LEN_W),
      .MAXLEN(MAXLEN)
    ) u_fsm (
      .clk   (clk),
      .rst   (rst),
      .vld   (vld[g]),
      .eof   (eof[g]),
      .rt_ra (rt_ra[g]),
      .rt_err(rt_err[g]),
      .ai2cb (ai2cb[g]),
      .nack  (nack[g]),
      .rt_rst(rt_rst[g]),
      .busy  (busy[g]),
      .ovf   (ovf[g])
    );
  end

endmodule

// File: tb/tb_subc_ctl_bank.sv
// Bench for subc_ctl_bank: two instances (MAXLEN 32 and 4) share stimulus and
// are compared each cycle against a frame-level reference model.
module tb_subc_ctl_bank;

  localparam int ML_A = 32;
  localparam int ML_B = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld, eof, rt_ra, rt_err, ai2cb;
  logic [3:0] nack_a, rt_rst_a, busy_a, ovf_a;
  logic [3:0] nack_b, rt_rst_b, busy_b, ovf_b;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance/lane, is a frame open, is it being dropped,
  // is a release pending, flits popped so far, overflow pulse.
  bit m_open [2][4];
  bit m_drop [2][4];
  bit m_rel  [2][4];
  bit m_ovf  [2][4];
  int m_cnt  [2][4];

  always #5 clk = ~clk;

  subc_ctl_bank dut_a (
    .clk(clk), .rst(rst), .vld(vld), .eof(eof), .rt_ra(rt_ra), .rt_err(rt_err),
    .ai2cb(ai2cb), .nack(nack_a), .rt_rst(rt_rst_a), .busy(busy_a), .ovf(ovf_a)
  );

  subc_ctl_bank #(.MAXLEN(ML_B)) dut_b (
    .clk(clk), .rst(rst), .vld(vld), .eof(eof), .rt_ra(rt_ra), .rt_err(rt_err),
    .ai2cb(ai2cb), .nack(nack_b), .rt_rst(rt_rst_b), .busy(busy_b), .ovf(ovf_b)
  );

  function automatic logic [3:0] exp_nack(int k);
    logic [3:0] e = '0;
    for (int l = 0; l < 4; l++)
      if (!rst && m_open[k][l])
        e[l] = m_drop[k][l] ? vld[l] : (vld[l] & ai2cb[l]);
    return e;
  endfunction

  function automatic logic [15:0] exp_inst(int k);
    logic [3:0] r, b, o;
    for (int l = 0; l < 4; l++) begin
      r[l] = m_rel[k][l];
      b[l] = m_open[k][l] | m_rel[k][l];
      o[l] = m_ovf[k][l];
    end
    return {exp_nack(k), r, b, o};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {exp_inst(0), exp_inst(1)};
  endfunction

  function automatic logic [31:0] obs();
    return {nack_a, rt_rst_a, busy_a, ovf_a, nack_b, rt_rst_b, busy_b, ovf_b};
  endfunction

  task automatic model_step();
    logic [3:0] pop [2];
    int lim;
    pop[0] = exp_nack(0);
    pop[1] = exp_nack(1);
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? ML_A : ML_B;
      for (int l = 0; l < 4; l++) begin
        if (rst) begin
          m_open[k][l] = 0; m_drop[k][l] = 0; m_rel[k][l] = 0;
          m_ovf[k][l] = 0;  m_cnt[k][l] = 0;
        end else begin
          m_ovf[k][l] = 0;
          if (m_rel[k][l]) begin
            if (!rt_ra[l]) begin m_rel[k][l] = 0; m_cnt[k][l] = 0; end
          end else if (m_open[k][l]) begin
            if (pop[k][l]) begin
              m_cnt[k][l]++;
              if (eof[l]) begin
                m_open[k][l] = 0; m_drop[k][l] = 0; m_rel[k][l] = 1;
              end else if (!m_drop[k][l] && m_cnt[k][l] == lim) begin
                m_drop[k][l] = 1; m_ovf[k][l] = 1;
              end
            end
          end else if (rt_err[l]) begin
            m_open[k][l] = 1; m_drop[k][l] = 1;
          end else if (rt_ra[l]) begin
            m_open[k][l] = 1; m_drop[k][l] = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    vld = '0; eof = '0; rt_ra = '0; rt_err = '0; ai2cb = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '1; ai2cb = '1; rt_ra = '1; eof = '0; rt_err = '0;
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if (nack_a !== 4'b0 || nack_b !== 4'b0) begin
        errors++; $display("FAIL reset_nack: got %h/%h want 0", nack_a, nack_b);
      end
      tick();
    end
    checks++;
    if (obs() !== 32'h0) begin
      errors++; $display("FAIL reset_state: got %h want 0", obs());
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_normal();
    int pops = 0;
    rt_ra[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vld[2] = (i >= 1 && i <= 3); ai2cb[2] = vld[2]; eof[2] = (i == 3);
      if (i == 5) rt_ra[2] = 1'b0;
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL normal c%0d: got %h want %h", i, obs(), exp_vec());
      end
      pops += int'(nack_a[2]);
      if (i == 4 || i == 5) begin
        checks++;
        if (rt_rst_a[2] !== 1'b1) begin
          errors++; $display("FAIL normal_rt_rst c%0d: got %b want 1", i, rt_rst_a[2]);
        end
      end
      tick();
    end
    checks++;
    if (pops != 3 || busy_a !== 4'b0 || rt_rst_a !== 4'b0) begin
      errors++; $display("FAIL normal_end: pops %0d busy %b rt_rst %b want 3 0000 0000", pops, busy_a, rt_rst_a);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    rt_ra[0] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      vld[0] = (i < 7); eof[0] = (i == 6);
      ai2cb[0] = (i < 4) ? pat[3-i] : 1'b1;
      if (i == 7) rt_ra[0] = 1'b0;
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL backpressure c%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (i < 4) begin
        checks++;
        if (nack_a[0] !== ai2cb[0]) begin
          errors++; $display("FAIL bp_mirror c%0d: got %b want %b", i, nack_a[0], ai2cb[0]);
        end
      end
      // Two pops in the pattern, so the 4-flit instance overflows on the 2nd extra pop.
      if (i == 6) begin
        checks++;
        if (ovf_b[0] !== 1'b1 || ovf_a[0] !== 1'b0) begin
          errors++; $display("FAIL bp_count: got ovf_b %b ovf_a %b want 1 0", ovf_b[0], ovf_a[0]);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_misroute();
    int rels = 0;
    rt_ra[1] = 1'b1; rt_err[1] = 1'b1;
    tick();
    rt_err[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vld[1] = (i < 4); eof[1] = (i == 3); ai2cb[1] = 1'b0;
      if (i == 4) begin rt_ra[1] = 1'b0; rt_err[1] = 1'b1; end
      if (i == 5) rt_err[1] = 1'b0;
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL misroute c%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (i < 4) begin
        checks++;
        if (nack_a[1] !== 1'b1) begin
          errors++; $display("FAIL misroute_drop c%0d: got %b want 1", i, nack_a[1]);
        end
      end
      rels += int'(rt_rst_a[1]);
      tick();
    end
    checks++;
    if (rels != 1) begin
      errors++; $display("FAIL misroute_rel: got %0d want 1", rels);
    end
    idle_inputs();
  endtask

  task automatic test_overlength();
    int ovfs = 0;
    rt_ra[3] = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      vld[3] = (i < 6); eof[3] = (i == 5); ai2cb[3] = (i < 6);
      if (i == 7) rt_ra[3] = 1'b0;
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL overlength c%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (ovf_b[3] !== 1'b1) begin
          errors++; $display("FAIL ovf_pulse: got %b want 1", ovf_b[3]);
        end
      end
      ovfs += int'(ovf_b[3]);
      tick();
    end
    checks++;
    if (ovfs != 1 || busy_b[3] !== 1'b0) begin
      errors++; $display("FAIL ovf_once: got %0d busy %b want 1 0", ovfs, busy_b[3]);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    rt_ra[0] = 1'b1;
    tick();
    vld[0] = 1'b1; ai2cb[0] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #4;
    checks++;
    if (nack_a[0] !== 1'b0 || nack_b[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_nack: got %b%b want 00", nack_a[0], nack_b[0]);
    end
    tick();
    rst = 1'b0; idle_inputs();
    #4;
    checks++;
    if (busy_a[0] !== 1'b0 || rt_rst_a[0] !== 1'b0 || nack_a[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_state: got busy %b rt_rst %b nack %b want 000", busy_a[0], rt_rst_a[0], nack_a[0]);
    end
    tick();
    rt_ra[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vld[0] = (i >= 1 && i <= 5); ai2cb[0] = vld[0]; eof[0] = (i == 5);
      if (i == 7) rt_ra[0] = 1'b0;
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL rstmid_frame c%0d: got %h want %h", i, obs(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if (ovf_b[0] !== 1'b1) begin
          errors++; $display("FAIL rstmid_count: got ovf %b want 1", ovf_b[0]);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_parallel();
    int len [4] = '{1, 2, 5, 3};
    rt_ra = '1;
    tick();
    for (int i = 0; i < 7; i++) begin
      for (int l = 0; l < 4; l++) begin
        vld[l] = (i < len[l]); eof[l] = (i == len[l] - 1); ai2cb[l] = 1'b1;
      end
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL parallel c%0d: got %h want %h", i, obs(), exp_vec());
      end
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (rt_rst_a[l] !== (i >= len[l])) begin
          errors++; $display("FAIL parallel_rt_rst c%0d l%0d: got %b want %b", i, l, rt_rst_a[l], i >= len[l]);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(99) == 0);
      for (int l = 0; l < 4; l++) begin
        if (!rt_ra[l] && !m_open[0][l] && !m_rel[0][l]) rt_ra[l] = ($urandom_range(3) == 0);
        else if (m_rel[0][l]) rt_ra[l] = $urandom_range(1);
        rt_err[l] = ($urandom_range(7) == 0);
        vld[l]    = ($urandom_range(3) != 0);
        eof[l]    = vld[l] & ($urandom_range(3) == 0);
        ai2cb[l]  = $urandom_range(1);
      end
      #4;
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random c%0d: got %h want %h", i, obs(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 4; l++) begin
        m_open[k][l] = 0; m_drop[k][l] = 0; m_rel[k][l] = 0;
        m_ovf[k][l] = 0;  m_cnt[k][l] = 0;
      end
    tick();
    test_reset();
    test_normal();
    test_backpressure();
    test_misroute();
    test_overlength();
    test_reset_mid();
    test_parallel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
